// File: rtl/ccs_rr_merge.sv
// N-channel ccs merge: round-robin arbiter into a tagged output FIFO
// with programmable idle cycles after each output transfer.
module ccs_rr_merge #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int DEPTH = 4,
    localparam int CHW  = $clog2(NCH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       in_vld,
    output logic [NCH-1:0]       in_rdy,
    input  logic [NCH*WIDTH-1:0] in_dat,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [WIDTH-1:0]     out_dat,
    output logic [CHW-1:0]       out_ch,
    input  logic [7:0]           stall_cycles,
    output logic [CW-1:0]        fifo_cnt
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STALL  = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [7:0]          ctr, ctr_nxt;
    logic [CHW-1:0]      ptr;
    logic [CHW-1:0]      g;
    logic [CHW:0]        idx;
    logic                hit;
    logic                full;
    logic                push, pop;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [AW-1:0]       rd, wr;
    logic [CHW+WIDTH-1:0] mem [DEPTH];

    // rotate the search origin to ptr; first valid channel wins
    always_comb begin
        g   = '0;
        hit = 1'b0;
        idx = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = {1'b0, ptr} + (CHW+1)'(k);
            if (idx >= (CHW+1)'(NCH))
                idx = idx - (CHW+1)'(NCH);
            if (!hit && in_vld[idx[CHW-1:0]]) begin
                hit = 1'b1;
                g   = idx[CHW-1:0];
            end
        end
    end

    assign full = (cnt == CW'(DEPTH));

    always_comb begin
        in_rdy = '0;
        if (rst && hit && !full)
            in_rdy[g] = 1'b1;
    end

    assign push     = rst && hit && !full;
    assign pop      = (state == ACTIVE) && out_rdy;
    assign cnt_nxt  = cnt + CW'(push) - CW'(pop);
    assign fifo_cnt = cnt;
    assign out_dat  = mem[rd][WIDTH-1:0];
    assign out_ch   = mem[rd][CHW+WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
            cnt <= '0;
            rd  <= '0;
            wr  <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            cnt <= cnt_nxt;
            if (push) begin
                mem[wr] <= {g, in_dat[g*WIDTH +: WIDTH]};
                wr      <= wr + 1'b1;
                ptr     <= (g == CHW'(NCH - 1)) ? '0 : g + 1'b1;
            end
            if (pop)
                rd <= rd + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ctr   <= '0;
        end else begin
            state <= state_nxt;
            ctr   <= ctr_nxt;
        end
    end

    // next-state uses post-edge occupancy so a push into an empty FIFO shows at once
    always_comb begin
        state_nxt = state;
        ctr_nxt   = ctr;
        out_vld   = 1'b0;
        unique case (state)
            IDLE: begin
                if (cnt_nxt != '0)
                    state_nxt = ACTIVE;
            end
            ACTIVE: begin
                out_vld = 1'b1;
                if (out_rdy) begin
                    if (stall_cycles != 8'd0) begin
                        ctr_nxt   = stall_cycles;
                        state_nxt = STALL;
                    end else if (cnt_nxt == '0) begin
                        state_nxt = IDLE;
                    end
                end
            end
            STALL: begin
                ctr_nxt = ctr - 8'd1;
                if (ctr == 8'd1)
                    state_nxt = (cnt_nxt != '0) ? ACTIVE : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ccs_rr_merge.sv
// Randomised and directed bench for ccs_rr_merge against a queue-based
// reference model of arbitration, buffering and post-transfer idling.
module tb_ccs_rr_merge;

    localparam int WIDTH = 32;
    localparam int NCH   = 4;
    localparam int DEPTH = 4;
    localparam int CHW   = $clog2(NCH);
    localparam int CW    = $clog2(DEPTH + 1);

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NCH-1:0]       in_vld = '0;
    logic [NCH-1:0]       in_rdy;
    logic [NCH*WIDTH-1:0] in_dat = '0;
    logic                 out_vld;
    logic                 out_rdy = 1'b0;
    logic [WIDTH-1:0]     out_dat;
    logic [CHW-1:0]       out_ch;
    logic [7:0]           stall_cycles = '0;
    logic [CW-1:0]        fifo_cnt;

    ccs_rr_merge #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_vld       (in_vld),
        .in_rdy       (in_rdy),
        .in_dat       (in_dat),
        .out_vld      (out_vld),
        .out_rdy      (out_rdy),
        .out_dat      (out_dat),
        .out_ch       (out_ch),
        .stall_cycles (stall_cycles),
        .fifo_cnt     (fifo_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               ch;
        logic [WIDTH-1:0] d;
    } ent_t;

    ent_t q[$];
    int   ptr = 0;
    int   blk = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic [NCH-1:0] v, input logic r,
                        input logic [7:0] s);
        int               g;
        logic [NCH-1:0]   er;
        logic             ev;
        logic [WIDTH-1:0] wd;
        @(negedge clk);
        in_vld       = v;
        out_rdy      = r;
        stall_cycles = s;
        for (int i = 0; i < NCH; i++)
            in_dat[i*WIDTH +: WIDTH] = $urandom;
        #1;
        g = -1;
        for (int k = 0; k < NCH; k++) begin
            int c;
            c = (ptr + k) % NCH;
            if (g < 0 && v[c])
                g = c;
        end
        er = '0;
        wd = '0;
        if (g >= 0) begin
            wd = in_dat[g*WIDTH +: WIDTH];
            if (q.size() < DEPTH)
                er[g] = 1'b1;
        end
        ev = (q.size() > 0) && (blk == 0);
        chk("in_rdy", 64'(in_rdy), 64'(er));
        chk("out_vld", 64'(out_vld), 64'(ev));
        chk("fifo_cnt", 64'(fifo_cnt), 64'(q.size()));
        if (ev) begin
            chk("out_dat", 64'(out_dat), 64'(q[0].d));
            chk("out_ch", 64'(out_ch), 64'(q[0].ch));
        end
        @(posedge clk);
        if (ev && r) begin
            void'(q.pop_front());
            blk = int'(s);
        end else if (blk > 0) begin
            blk--;
        end
        if (er != '0) begin
            q.push_back('{g, wd});
            ptr = (g + 1) % NCH;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b0;
        in_vld = '1;
        #1;
        chk("rst_out_vld", 64'(out_vld), 64'd0);
        chk("rst_fifo_cnt", 64'(fifo_cnt), 64'd0);
        chk("rst_in_rdy", 64'(in_rdy), 64'd0);
        chk("rst_out_dat", 64'(out_dat), 64'd0);
        chk("rst_out_ch", 64'(out_ch), 64'd0);
        q.delete();
        ptr = 0;
        blk = 0;
        @(negedge clk);
        chk("rst_hold_vld", 64'(out_vld), 64'd0);
        chk("rst_hold_cnt", 64'(fifo_cnt), 64'd0);
        in_vld = '0;
        rst    = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 12; i++)
            step('0, 1'b1, 8'd0);
    endtask

    initial begin
        do_reset();

        // all channels busy, no stall: 0,1,2,3,0,...
        for (int i = 0; i < 20; i++)
            step('1, 1'b1, 8'd0);
        drain();

        // ch1 against a blocked sink, then release
        for (int i = 0; i < 6; i++)
            step(4'b0010, 1'b0, 8'd0);
        for (int i = 0; i < 10; i++)
            step(4'b0010, 1'b1, 8'd0);
        drain();

        // FIFO kept full with 3 idle cycles after each beat
        for (int i = 0; i < 30; i++)
            step('1, 1'b1, 8'd3);
        drain();

        // single active channel streams every cycle
        for (int i = 0; i < 12; i++)
            step(4'b0100, 1'b1, 8'd0);
        drain();

        // full FIFO with simultaneous pop and ch0 offer
        for (int i = 0; i < 6; i++)
            step(4'b0001, 1'b0, 8'd0);
        for (int i = 0; i < 6; i++)
            step(4'b0001, 1'b1, 8'd0);
        drain();

        // reset with 3 entries queued
        for (int i = 0; i < 3; i++)
            step(4'b0001, 1'b0, 8'd0);
        do_reset();
        for (int i = 0; i < 6; i++)
            step(4'b1000, 1'b1, 8'd0);

        // random traffic, back-pressure and stall lengths
        for (int i = 0; i < 2000; i++) begin
            logic [NCH-1:0] v;
            logic           r;
            logic [7:0]     s;
            v = NCH'($urandom);
            r = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 4)) : 8'd0;
            step(v, r, s);
        end

        do_reset();
        step('1, 1'b1, 8'd0);
        step('1, 1'b1, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
